bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_pkg.sv | 15 +
 rtl/bus_timer_if.sv | 10 +
 rtl/bus_timer_prescaler.sv | 17 +
 rtl/bus_timer.sv | 102 ++++++++++
 tb/tb_bus_timer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register offsets, CTRL/STATUS bit indices and FSM states for bus_timer
package bus_timer_pkg;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CAP    = 3'd5;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STAT_MATCH = 0;
  localparam int STAT_CAPF  = 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/bus_timer_if.sv
// bus_timer_if: CPU data-bus signals between the CPU (master) and bus_timer (slave)
interface bus_timer_if;
  logic [15:0] Addr;
  logic [15:0] Din;
  logic        write;
  logic [15:0] Dout;
  logic        irq;
  modport master (output Addr, Din, write, input Dout, irq);
  modport slave  (input Addr, Din, write, output Dout, irq);
endinterface

// File: rtl/bus_timer_prescaler.sv
// timer_prescaler: free-running divider producing a one-cycle tick when the counter reaches PRESC
module timer_prescaler (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [15:0] i_presc,
  output logic        o_tick
);
  logic [15:0] r_cnt;
  assign o_tick = i_enable && !i_clear && r_cnt == i_presc;
  // count up while enabled, wrapping to 0 on the tick; a clear restarts the period
  always_ff @(posedge clk_bus or posedge rst_bus)
    if (rst_bus) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_enable) r_cnt <= o_tick ? 16'd0 : r_cnt + 16'd1;
endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped compare timer with auto-reload and irq; input capture when BUS_TIMER_CAPTURE_EN is defined
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input logic clk_bus,
  input logic rst_bus,
`ifdef BUS_TIMER_CAPTURE_EN
  input logic cap_in,
`endif
  bus_timer_if.slave bus
);
  state_t      r_state, w_next;
  logic        r_auto, r_ie, r_match, r_capf, r_irq;
  logic [15:0] r_presc, r_count, r_cmp, w_cap, w_rd;
  logic        w_sel, w_wr, w_wr_ctrl, w_wr_presc, w_wr_count, w_wr_cmp, w_wr_status;
  logic        w_tick, w_match, w_cap_evt;
  logic [2:0]  w_off;

  assign w_sel       = bus.Addr[15:3] == BASE_ADDR[15:3];
  assign w_off       = bus.Addr[2:0];
  assign w_wr        = bus.write && w_sel;
  assign w_wr_ctrl   = w_wr && w_off == OFF_CTRL;
  assign w_wr_presc  = w_wr && w_off == OFF_PRESC;
  assign w_wr_count  = w_wr && w_off == OFF_COUNT;
  assign w_wr_cmp    = w_wr && w_off == OFF_CMP;
  assign w_wr_status = w_wr && w_off == OFF_STATUS;
  assign w_match     = w_tick && r_count == r_cmp;

  timer_prescaler u_presc (
    .clk_bus (clk_bus),
    .rst_bus (rst_bus),
    .i_clear (r_state != S_RUN || w_wr_ctrl),
    .i_enable(r_state == S_RUN),
    .i_presc (r_presc),
    .o_tick  (w_tick)
  );

`ifdef BUS_TIMER_CAPTURE_EN
  logic [2:0]  r_sync;
  logic [15:0] r_cap;
  // two synchronizer flops followed by a delay flop for rising-edge detection
  always_ff @(posedge clk_bus or posedge rst_bus)
    if (rst_bus) r_sync <= '0;
    else r_sync <= {r_sync[1:0], cap_in};
  assign w_cap_evt = r_sync[1] && !r_sync[2] && r_state == S_RUN;
  // latch COUNT on a synchronized rising edge of cap_in
  always_ff @(posedge clk_bus or posedge rst_bus)
    if (rst_bus) r_cap <= '0;
    else if (w_cap_evt) r_cap <= r_count;
  assign w_cap = r_cap;
`else
  assign w_cap_evt = 1'b0;
  assign w_cap     = '0;
`endif

  // state register
  always_ff @(posedge clk_bus or posedge rst_bus)
    if (rst_bus) r_state <= S_IDLE;
    else r_state <= w_next;

  // an EN write selects RUN/IDLE from any state; a one-shot match parks in DONE
  always_comb
    w_next = w_wr_ctrl ? (bus.Din[CTRL_EN] ? S_RUN : S_IDLE) :
             (w_match && !r_auto) ? S_DONE : r_state;

  // registers: CPU COUNT write beats the tick, hardware flag set beats write-1-clear
  always_ff @(posedge clk_bus or posedge rst_bus)
    if (rst_bus) begin
      r_auto  <= 1'b0;
      r_ie    <= 1'b0;
      r_presc <= '0;
      r_cmp   <= '0;
      r_count <= '0;
      r_match <= 1'b0;
      r_capf  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_auto <= bus.Din[CTRL_AUTO];
        r_ie   <= bus.Din[CTRL_IE];
      end
      if (w_wr_presc) r_presc <= bus.Din;
      if (w_wr_cmp) r_cmp <= bus.Din;
      r_count <= w_wr_count ? bus.Din :
                 w_match ? (r_auto ? 16'd0 : r_count) :
                 w_tick ? r_count + 16'd1 : r_count;
      r_match <= w_match || (r_match && !(w_wr_status && bus.Din[STAT_MATCH]));
      r_capf  <= w_cap_evt || (r_capf && !(w_wr_status && bus.Din[STAT_CAPF]));
      r_irq   <= r_ie && (w_match || w_cap_evt);
    end

  assign w_rd = w_off == OFF_CTRL   ? {13'd0, r_ie, r_auto, r_state == S_RUN} :
                w_off == OFF_PRESC  ? r_presc :
                w_off == OFF_COUNT  ? r_count :
                w_off == OFF_CMP    ? r_cmp :
                w_off == OFF_STATUS ? {14'd0, r_capf, r_match} :
                w_off == OFF_CAP    ? w_cap : 16'h0000;
  assign bus.Dout = w_sel ? w_rd : 16'h0000;
  assign bus.irq  = r_irq;
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed and randomized checks of bus_timer against an arithmetic tick/count model
module tb_bus_timer;
  import bus_timer_pkg::*;
  localparam logic [15:0] BASE = 16'hFF00;
  logic clk_bus = 1'b0;
  logic rst_bus = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] v;
  bus_timer_if bus();
`ifdef BUS_TIMER_CAPTURE_EN
  logic cap_in = 1'b0;
`endif

  bus_timer #(.BASE_ADDR(BASE)) dut (
    .clk_bus(clk_bus),
    .rst_bus(rst_bus),
`ifdef BUS_TIMER_CAPTURE_EN
    .cap_in (cap_in),
`endif
    .bus    (bus)
  );

  always #5 clk_bus = ~clk_bus;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    @(negedge clk_bus);
    bus.Addr  = BASE + {13'd0, off};
    bus.Din   = d;
    bus.write = 1'b1;
    @(posedge clk_bus);
    #1 bus.write = 1'b0;
  endtask

  task automatic rda(input logic [15:0] a, output logic [15:0] d);
    bus.Addr = a;
    #1 d = bus.Dout;
  endtask

  task automatic rd(input logic [2:0] off, output logic [15:0] d);
    rda(BASE + {13'd0, off}, d);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk_bus);
    #1;
  endtask

  // After i edges of RUN, ticks completed = i/(p+1); COUNT, EN, MATCH and irq follow from that.
  task automatic run_model(input int p, input int c, input bit auto_r, input bit ie, input int ncyc);
    int t;
    logic [15:0] d;
    int ecnt;
    bit een, emat, eirq;
    wr(OFF_CTRL, 16'h0);
    wr(OFF_STATUS, 16'h3);
    wr(OFF_COUNT, 16'h0);
    wr(OFF_PRESC, 16'(p));
    wr(OFF_CMP, 16'(c));
    wr(OFF_CTRL, {13'd0, ie, auto_r, 1'b1});
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_bus);
      t = i / (p + 1);
      if (auto_r) begin
        ecnt = t % (c + 1);
        een  = 1'b1;
        emat = t > c;
        eirq = ie && i > 0 && i % (p + 1) == 0 && t % (c + 1) == 0;
      end else begin
        ecnt = t > c ? c : t;
        een  = t <= c;
        emat = t > c;
        eirq = ie && i == (c + 1) * (p + 1);
      end
      rd(OFF_COUNT, d);
      chk($sformatf("p%0d c%0d a%0d i%0d count", p, c, auto_r, i), d, 16'(ecnt));
      chk($sformatf("p%0d c%0d a%0d i%0d irq", p, c, auto_r, i), {15'd0, bus.irq}, {15'd0, eirq});
      rd(OFF_CTRL, d);
      chk($sformatf("p%0d c%0d a%0d i%0d en", p, c, auto_r, i), {15'd0, d[CTRL_EN]}, {15'd0, een});
      rd(OFF_STATUS, d);
      chk($sformatf("p%0d c%0d a%0d i%0d match", p, c, auto_r, i), {15'd0, d[STAT_MATCH]}, {15'd0, emat});
    end
  endtask

  initial begin
    logic [15:0] seq [5];
    seq = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0002};
    bus.Addr  = 16'h0;
    bus.Din   = 16'h0;
    bus.write = 1'b0;
    #2;
    rd(OFF_CTRL, v);  chk("reset ctrl", v, 16'h0);
    rd(OFF_COUNT, v); chk("reset count", v, 16'h0);
    rda(16'h1234, v); chk("reset unselected", v, 16'h0);
    chk("reset irq", {15'd0, bus.irq}, 16'h0);
    @(negedge clk_bus);
    rst_bus = 1'b0;

    run_model(1, 3, 1'b1, 1'b1, 20);
    run_model(0, 5, 1'b0, 1'b1, 10);
    for (int r = 0; r < 6; r++)
      run_model(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 31);

    wr(OFF_CTRL, 16'h0);
    wr(OFF_STATUS, 16'h3);
    wr(OFF_COUNT, 16'h0);
    wr(OFF_PRESC, 16'h0);
    wr(OFF_CMP, 16'h2);
    wr(OFF_CTRL, 16'h3);
    idle(2);
    wr(OFF_STATUS, 16'h1);
    rd(OFF_STATUS, v); chk("set beats clear", {15'd0, v[STAT_MATCH]}, 16'h1);
    wr(OFF_STATUS, 16'h1);
    rd(OFF_STATUS, v); chk("clean clear", {15'd0, v[STAT_MATCH]}, 16'h0);

    wr(OFF_CTRL, 16'h0);
    wr(OFF_STATUS, 16'h3);
    wr(OFF_PRESC, 16'h0);
    wr(OFF_CMP, 16'h2);
    wr(OFF_COUNT, 16'hFFFF);
    wr(OFF_CTRL, 16'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_bus);
      rd(OFF_COUNT, v); chk($sformatf("wrap i%0d", i), v, seq[i]);
    end
    rd(OFF_CTRL, v);   chk("wrap done en", {15'd0, v[CTRL_EN]}, 16'h0);
    rd(OFF_STATUS, v); chk("wrap match", {15'd0, v[STAT_MATCH]}, 16'h1);

    wr(OFF_CTRL, 16'h0);
    wr(OFF_CMP, 16'hFFF0);
    wr(OFF_COUNT, 16'h0);
    wr(OFF_CTRL, 16'h3);
    wr(OFF_COUNT, 16'h0100);
    rd(OFF_COUNT, v); chk("count write priority", v, 16'h0100);
    idle(1);
    rd(OFF_COUNT, v); chk("count after write", v, 16'h0101);

    rda(BASE + 16'd8, v); chk("decode base+8", v, 16'h0);
    rda(BASE + 16'd6, v); chk("decode base+6", v, 16'h0);
    rda(BASE - 16'd1, v); chk("decode base-1", v, 16'h0);
    wr(3'd6, 16'hABCD);
    rd(3'd6, v); chk("reserved write ignored", v, 16'h0);

`ifdef BUS_TIMER_CAPTURE_EN
    wr(OFF_CTRL, 16'h0);
    wr(OFF_STATUS, 16'h3);
    wr(OFF_PRESC, 16'hFFFF);
    wr(OFF_COUNT, 16'h7);
    wr(OFF_CTRL, 16'h5);
    @(negedge clk_bus);
    cap_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      chk($sformatf("cap irq edge%0d", k), {15'd0, bus.irq}, {15'd0, k == 3});
    end
    rd(OFF_CAP, v);    chk("cap value", v, 16'h7);
    rd(OFF_STATUS, v); chk("capf", v, 16'h2);
    cap_in = 1'b0;
`endif

    wr(OFF_CTRL, 16'h0);
    wr(OFF_STATUS, 16'h3);
    wr(OFF_PRESC, 16'h0);
    wr(OFF_CMP, 16'h3);
    wr(OFF_COUNT, 16'h0);
    wr(OFF_CTRL, 16'h7);
    idle(4);
    chk("irq before reset", {15'd0, bus.irq}, 16'h1);
    rst_bus = 1'b1;
    #1;
    chk("async reset irq", {15'd0, bus.irq}, 16'h0);
    rd(OFF_CTRL, v);   chk("async reset ctrl", v, 16'h0);
    rd(OFF_PRESC, v);  chk("async reset presc", v, 16'h0);
    rd(OFF_COUNT, v);  chk("async reset count", v, 16'h0);
    rd(OFF_CMP, v);    chk("async reset cmp", v, 16'h0);
    rd(OFF_STATUS, v); chk("async reset status", v, 16'h0);
    @(negedge clk_bus);
    rst_bus = 1'b0;
    idle(3);
    chk("no irq after reset", {15'd0, bus.irq}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
